// File: rtl/hazard_unit.sv
// Pipeline hazard tracker: records E/M/W destination/Tnew state and derives stall and forwarding selects.
// Optional W-stage bypass (code 3 and fwd_rt_M) is enabled by defining HAZ_W_BYPASS_EN.
module hazard_unit (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] rs_D,
  input  logic [4:0] rt_D,
  input  logic [1:0] Tuse_rs,
  input  logic [1:0] Tuse_rt,
  input  logic [4:0] A3_D,
  input  logic [1:0] Tnew_D,
  output logic       stall,
  output logic       bubble_E,
  output logic [1:0] fwd_rs_D,
  output logic [1:0] fwd_rt_D,
  output logic [1:0] fwd_rs_E,
  output logic [1:0] fwd_rt_E,
  output logic       fwd_rt_M
);

`ifdef HAZ_W_BYPASS_EN
  localparam logic W_EN = 1'b1;
`else
  localparam logic W_EN = 1'b0;
`endif

  logic [4:0] a3_e, rs_e, rt_e;
  logic [1:0] tnew_e;
  logic [4:0] a3_m, rt_m;
  logic [1:0] tnew_m;
  logic [4:0] a3_w;

  // A source blocks when a producer in E or M cannot deliver before the consumer needs it.
  function automatic logic src_blocked(input logic [4:0] r, input logic [1:0] tuse,
                                       input logic [4:0] ae, input logic [1:0] te,
                                       input logic [4:0] am, input logic [1:0] tm);
    logic live;
    live = (r != 5'd0) && (tuse != 2'd3);
    return live && (((ae == r) && (te > tuse)) || ((am == r) && (tm > tuse)));
  endfunction

  function automatic logic [1:0] sel_d(input logic [4:0] r,
                                       input logic [4:0] ae, input logic [1:0] te,
                                       input logic [4:0] am, input logic [1:0] tm,
                                       input logic [4:0] aw);
    logic [1:0] sel;
    sel = 2'd0;
    if (r != 5'd0) begin
      if ((ae == r) && (te == 2'd0))      sel = 2'd1;
      else if ((am == r) && (tm == 2'd0)) sel = 2'd2;
      else if (W_EN && (aw == r))         sel = 2'd3;
    end
    return sel;
  endfunction

  function automatic logic [1:0] sel_e(input logic [4:0] r,
                                       input logic [4:0] am, input logic [1:0] tm,
                                       input logic [4:0] aw);
    logic [1:0] sel;
    sel = 2'd0;
    if (r != 5'd0) begin
      if ((am == r) && (tm == 2'd0)) sel = 2'd2;
      else if (W_EN && (aw == r))    sel = 2'd3;
    end
    return sel;
  endfunction

  always_comb begin
    stall    = src_blocked(rs_D, Tuse_rs, a3_e, tnew_e, a3_m, tnew_m) |
               src_blocked(rt_D, Tuse_rt, a3_e, tnew_e, a3_m, tnew_m);
    bubble_E = stall;
    fwd_rs_D = sel_d(rs_D, a3_e, tnew_e, a3_m, tnew_m, a3_w);
    fwd_rt_D = sel_d(rt_D, a3_e, tnew_e, a3_m, tnew_m, a3_w);
    fwd_rs_E = sel_e(rs_e, a3_m, tnew_m, a3_w);
    fwd_rt_E = sel_e(rt_e, a3_m, tnew_m, a3_w);
    fwd_rt_M = W_EN && (rt_m != 5'd0) && (a3_w == rt_m);
  end

  // A stalled D instruction stays in F/D, so E receives an empty record instead.
  always_ff @(posedge clk) begin
    if (reset) begin
      a3_e   <= 5'd0;
      tnew_e <= 2'd0;
      rs_e   <= 5'd0;
      rt_e   <= 5'd0;
      a3_m   <= 5'd0;
      tnew_m <= 2'd0;
      rt_m   <= 5'd0;
      a3_w   <= 5'd0;
    end else begin
      if (stall) begin
        a3_e   <= 5'd0;
        tnew_e <= 2'd0;
        rs_e   <= 5'd0;
        rt_e   <= 5'd0;
      end else begin
        a3_e   <= A3_D;
        tnew_e <= Tnew_D;
        rs_e   <= rs_D;
        rt_e   <= rt_D;
      end
      a3_m   <= a3_e;
      tnew_m <= (tnew_e == 2'd0) ? 2'd0 : tnew_e - 2'd1;
      rt_m   <= rt_e;
      a3_w   <= a3_m;
    end
  end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard tracker for the 5-stage MIPS core; sits directly downstream of the D-stage controller and consumes its `Tuse_rs`, `Tuse_rt` and `A3` outputs. It keeps a registered record (destination register, Tnew, source registers) for each in-flight instruction in E, M and W. From that record it produces the F/D stall, the D/E bubble, and operand-forwarding selects for the D, E and M stages.

## Interface
- No parameters.
- `clk` in 1: core clock, rising edge.
- `reset` in 1: synchronous, active-high. One clock; reset is synchronous and active-high.
- `rs_D` in 5: rs field of the instruction in D.
- `rt_D` in 5: rt field of the instruction in D.
- `Tuse_rs` in 2: cycles until D instruction needs rs (0 = in D, 1 = in E, 2 = in M, 3 = unused).
- `Tuse_rt` in 2: same for rt.
- `A3_D` in 5: destination register of D instruction (0 = no write).
- `Tnew_D` in 2: cycles after entering E until its result sits in a pipeline register (0 = available in E, 1 = ALU, 2 = load).
- `stall` out 1: hold PC and F/D register.
- `bubble_E` out 1: load NOP into D/E; equal to `stall`.
- `fwd_rs_D` out 2: D-stage rs source (0 regfile, 1 E, 2 M, 3 W).
- `fwd_rt_D` out 2: same for rt.
- `fwd_rs_E` out 2: E-stage rs source (0 D/E register, 2 M, 3 W).
- `fwd_rt_E` out 2: same for rt.
- `fwd_rt_M` out 1: M-stage rt source for stores (0 E/M register, 1 W).

## Operation
- Slot E holds {A3, Tnew, rs, rt}, slot M holds {A3, Tnew, rt}, and slot W holds {A3}. All fields reset to 0.
- A source is "live" when its register number is nonzero and its Tuse is not 3.
- Stall condition, evaluated for rs and rt independently and ORed:
  - live and A3_E == reg and Tnew_E > Tuse; or
  - live and A3_M == reg and Tnew_M > Tuse.
  - W never causes a stall.
- On each rising edge when not in reset:
  - E slot ← {A3_D, Tnew_D, rs_D, rt_D} if `stall` = 0; otherwise bubble {0, 0, 0, 0}.
  - M slot ← {A3_E, sat(Tnew_E − 1), rt_E}.
  - W slot ← {A3_M}.
  - sat() clamps at 0; Tnew is 2 bits and never wraps.
- D forwarding: choose the first matching slot in priority order E, M, W.
  - E matches when A3_E == reg ≠ 0 and Tnew_E == 0.
  - M matches when A3_M == reg ≠ 0 and Tnew_M == 0.
  - W matches when A3_W == reg ≠ 0.
  - No match → 0.
- E forwarding uses rs_E/rt_E with the same M-then-W priority. It never selects E.
- M forwarding: `fwd_rt_M` = 1 iff A3_W == rt_M ≠ 0.
- Register $0 never stalls and never forwards.
- A forward select is produced regardless of Tuse. Consumers ignore it when the source is unused.
- Simultaneous match in several slots: the youngest slot wins.
- Reset mid-stall: the next cycle starts from empty slots, with `stall` = 0.

## Timing
- All outputs are combinational from the slot registers and the D-stage inputs, valid in the same cycle. There are no output registers.
- Reset value of every output is 0 while slots are empty.
- Slots update only on the clock edge; latency from D inputs to the E slot is 1 cycle.
- A load-use pair (Tnew 2, consumer Tuse 1) stalls exactly 1 cycle.
- A load followed by a Tuse 0 consumer stalls 2 cycles.
- An ALU result followed by a Tuse 0 consumer stalls 1 cycle.
- `stall` deasserts on the cycle the blocking slot's Tnew ≤ Tuse.

## Configuration
- `HAZ_W_BYPASS_EN` defined:
  - W slot participates in D and E forwarding (code 3).
  - `fwd_rt_M` is active.
- `HAZ_W_BYPASS_EN` undefined:
  - W never matches; `fwd_*_D` and `fwd_*_E` never equal 3, and `fwd_rt_M` is tied 0.
  - The register file must provide write-through.
  - Stall logic is identical in both builds.

## Test plan
- Reset held 2 cycles, D inputs all 0 → `stall` = 0, all fwd = 0; the next 3 cycles stay 0.
- lw with A3_D = 1, Tnew_D = 2, followed by addu with rs_D = 1, Tuse_rs = 1 → `stall` = `bubble_E` = 1 for one cycle; addu reaches E with `fwd_rs_E` = 3 (macro on).
- addu with A3_D = 2, Tnew_D = 1, followed by beq with rs_D = 2, Tuse_rs = 0 → 1-cycle stall, then `fwd_rs_D` = 2.
- Writer with A3_D = 0, Tnew_D = 2, followed by consumer rs_D = 0, Tuse_rs = 0 → `stall` = 0, `fwd_rs_D` = 0.
- jal with A3_D = 31, Tnew_D = 0 in E and an ALU writer to 31 in M, D jr with rs_D = 31, Tuse_rs = 0 → `stall` = 0, `fwd_rs_D` = 1 (E wins).
- Macro off: writer to $5 in W, D rt_D = 5 → `fwd_rt_D` = 0; a sw with rt = 5 in M gives `fwd_rt_M` = 0.
